// File: rtl/topk_stream_sorter.sv
// topk_stream_sorter: collects a frame of N unsigned scores (ID = arrival
// index) and keeps the K best in a sorted table with single-cycle parallel
// insertion. The ranked result is published with a one-cycle done pulse.
// Optional build macro: TOPK_MIN_MODE_EN keeps the K smallest scores instead
// of the K largest.
module topk_stream_sorter #(
    parameter int N     = 64,
    parameter int WIDTH = 16,
    parameter int IDW   = 6,
    parameter int K     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_score,
    output logic [K*WIDTH-1:0]   topk_vals,
    output logic [K*IDW-1:0]     topk_ids,
    output logic                 busy,
    output logic                 done
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    // Parameter sanity checks at elaboration time.
    generate
        if (N < K) begin : g_bad_n
            $error("topk_stream_sorter: N must be >= K");
        end
        if ((2 ** IDW) < N) begin : g_bad_idw
            $error("topk_stream_sorter: 2**IDW must be >= N");
        end
        if ((K < 1) || (K > 32)) begin : g_bad_k
            $error("topk_stream_sorter: K must be in 1..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             clear_tbl;
    logic             accept;
    logic             last_accept;

    logic [IDW-1:0]   id_reg;

    logic [WIDTH-1:0] tbl_val_reg [K];
    logic [IDW-1:0]   tbl_id_reg  [K];
    logic [K-1:0]     tbl_vld_reg;

    logic [WIDTH-1:0] ins_val [K];
    logic [IDW-1:0]   ins_id  [K];
    logic [K-1:0]     ins_vld;
    logic [K-1:0]     better;

    logic [WIDTH-1:0] out_val_reg [K];
    logic [IDW-1:0]   out_id_reg  [K];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake decode; start always wins over a score.
    always_comb begin
        state_next  = state_reg;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        clear_tbl   = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                    clear_tbl  = 1'b1;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (start) begin
                    clear_tbl = 1'b1;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (id_reg == LAST_ID) begin
                        last_accept = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = COLLECT;
                    clear_tbl  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-slot insertion network. better[] is a prefix mask because the table
    // is sorted with valid entries first; an equal score loses to the resident
    // entry so earlier IDs win ties.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_slot
`ifdef TOPK_MIN_MODE_EN
            assign better[gi] = tbl_vld_reg[gi] && (tbl_val_reg[gi] <= in_score);
`else
            assign better[gi] = tbl_vld_reg[gi] && (tbl_val_reg[gi] >= in_score);
`endif
            if (gi == 0) begin : g_head
                // Slot insertion for the top rank: keep or take the new score.
                always_comb begin
                    ins_val[gi] = tbl_val_reg[gi];
                    ins_id[gi]  = tbl_id_reg[gi];
                    ins_vld[gi] = tbl_vld_reg[gi];
                    if (!better[gi]) begin
                        ins_val[gi] = in_score;
                        ins_id[gi]  = id_reg;
                        ins_vld[gi] = 1'b1;
                    end
                end
            end else begin : g_body
                // Keep, take the new score, or shift down from the slot above.
                always_comb begin
                    ins_val[gi] = tbl_val_reg[gi];
                    ins_id[gi]  = tbl_id_reg[gi];
                    ins_vld[gi] = tbl_vld_reg[gi];
                    if (!better[gi]) begin
                        if (better[gi-1]) begin
                            ins_val[gi] = in_score;
                            ins_id[gi]  = id_reg;
                            ins_vld[gi] = 1'b1;
                        end else begin
                            ins_val[gi] = tbl_val_reg[gi-1];
                            ins_id[gi]  = tbl_id_reg[gi-1];
                            ins_vld[gi] = tbl_vld_reg[gi-1];
                        end
                    end
                end
            end
            assign topk_vals[(K-1-gi)*WIDTH +: WIDTH] = out_val_reg[gi];
            assign topk_ids[(K-1-gi)*IDW +: IDW]      = out_id_reg[gi];
        end
    endgenerate

    // Working table and ID counter; the counter stops on the last accept so
    // it never wraps inside a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_reg      <= '0;
            tbl_vld_reg <= '0;
            for (int i = 0; i < K; i++) begin
                tbl_val_reg[i] <= '0;
                tbl_id_reg[i]  <= '0;
            end
        end else if (clear_tbl) begin
            id_reg      <= '0;
            tbl_vld_reg <= '0;
        end else if (accept) begin
            if (!last_accept) begin
                id_reg <= id_reg + 1'b1;
            end
            tbl_vld_reg <= ins_vld;
            for (int i = 0; i < K; i++) begin
                tbl_val_reg[i] <= ins_val[i];
                tbl_id_reg[i]  <= ins_id[i];
            end
        end
    end

    // Published result: captured with the final insertion so it is visible in
    // the same cycle done is high, then held until the next completed frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                out_val_reg[i] <= '0;
                out_id_reg[i]  <= '0;
            end
        end else if (last_accept) begin
            for (int i = 0; i < K; i++) begin
                out_val_reg[i] <= ins_val[i];
                out_id_reg[i]  <= ins_id[i];
            end
        end
    end

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Scoreboard bench for topk_stream_sorter: frames are driven with random
// flow gaps, a sort-by-selection reference model predicts each result, and a
// monitor checks every done pulse against the queue.
module tb_topk_stream_sorter;

    localparam int N     = 64;
    localparam int WIDTH = 16;
    localparam int IDW   = 6;
    localparam int K     = 10;
    localparam int VW    = K * WIDTH;
    localparam int IW    = K * IDW;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_score = '0;
    logic [VW-1:0]    topk_vals;
    logic [IW-1:0]    topk_ids;
    logic             busy;
    logic             done;

    topk_stream_sorter #(.N(N), .WIDTH(WIDTH), .IDW(IDW), .K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .topk_vals (topk_vals),
        .topk_ids  (topk_ids),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [VW-1:0] v;
        logic [IW-1:0] id;
        int            dcyc;
    } exp_t;

    exp_t exp_q[$];
    int   frame_sc [N];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // True when score a outranks score b (ties resolved by caller's scan order).
    function automatic bit outranks(input int a, input int b);
`ifdef TOPK_MIN_MODE_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    // Reference: repeatedly pick the best unused score, lowest ID on ties.
    function automatic exp_t model(input int done_cycle);
        exp_t e;
        bit   used [N];
        int   best;
        e.v = '0;
        e.id = '0;
        e.dcyc = done_cycle;
        for (int j = 0; j < N; j++) used[j] = 1'b0;
        for (int r = 0; r < K; r++) begin
            best = -1;
            for (int j = 0; j < N; j++)
                if (!used[j] && (best < 0 || outranks(frame_sc[j], frame_sc[best])))
                    best = j;
            used[best] = 1'b1;
            e.v[(K-1-r)*WIDTH +: WIDTH] = WIDTH'(frame_sc[best]);
            e.id[(K-1-r)*IDW +: IDW]    = IDW'(best);
        end
        return e;
    endfunction

    // Drive a full frame. gap_mode: 0 back-to-back, 1 alternate idle cycle,
    // 2 random idle cycles. The expectation is queued before the final accept.
    task automatic run_frame(input int gap_mode, input bit start_with_valid);
        int g;
        @(negedge clk);
        start    = 1'b1;
        in_valid = start_with_valid;
        in_score = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_score = WIDTH'(frame_sc[i]);
            if (i == N - 1) exp_q.push_back(model(cyc + 1));
            @(negedge clk);
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (i == N - 1) g = 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_score = WIDTH'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) frame_sc[i] = i * 3;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", VW'(cyc), VW'(e.dcyc));
                for (int r = 0; r < K; r++) begin
                    check($sformatf("rank%0d_val", r), VW'(topk_vals[(K-1-r)*WIDTH +: WIDTH]),
                          VW'(e.v[(K-1-r)*WIDTH +: WIDTH]));
                    check($sformatf("rank%0d_id", r), VW'(topk_ids[(K-1-r)*IDW +: IDW]),
                          VW'(e.id[(K-1-r)*IDW +: IDW]));
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_vals", topk_vals, '0);
        check("rst_ids", VW'(topk_ids), '0);
        check("rst_done", VW'(done), '0);
        check("rst_busy", VW'(busy), '0);
        check("rst_ready", VW'(in_ready), '0);
        reset = 1'b0;

        // Ramp frame, back-to-back; then confirm the result holds.
        fill_ramp();
        run_frame(0, 1'b0);
        repeat (3) @(negedge clk);
`ifdef TOPK_MIN_MODE_EN
        check("ramp_rank0_val", VW'(topk_vals[VW-1 -: WIDTH]), VW'(0));
        check("ramp_rank9_val", VW'(topk_vals[WIDTH-1:0]), VW'(27));
        check("ramp_rank9_id", VW'(topk_ids[IDW-1:0]), VW'(9));
`else
        check("ramp_rank0_val", VW'(topk_vals[VW-1 -: WIDTH]), VW'(189));
        check("ramp_rank9_val", VW'(topk_vals[WIDTH-1:0]), VW'(162));
        check("ramp_rank9_id", VW'(topk_ids[IDW-1:0]), VW'(54));
`endif

        // All-equal scores: earliest IDs win.
        for (int i = 0; i < N; i++) frame_sc[i] = 16'h0100;
        run_frame(0, 1'b0);

        // Ramp with toggling valid.
        fill_ramp();
        run_frame(1, 1'b0);

        // Scores offered in IDLE are ignored; start with in_valid high too.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_score = 16'hFFFF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        run_frame(0, 1'b1);

        // Abort mid-frame with a restart; the partial 0xFFFF scores must vanish.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("collect_busy", VW'(busy), VW'(1));
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_score = 16'hFFFF;
            @(negedge clk);
        end
        run_frame(2, 1'b1);

        // Reset after 30 accepts: outputs clear immediately, no done follows.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_score = WIDTH'(frame_sc[i]);
            if (i < 29) @(negedge clk);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_vals", topk_vals, '0);
        check("mid_rst_ids", VW'(topk_ids), '0);
        check("mid_rst_busy", VW'(busy), '0);
        check("mid_rst_ready", VW'(in_ready), '0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_done", VW'(done), '0);
        run_frame(0, 1'b0);

        // Random frames: narrow range for many ties, then full range.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++)
                frame_sc[i] = (f < 2) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
            run_frame(2, f[0]);
        end

        // Drain: every queued result must have been seen.
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/topk_stream_sorter.md
TOPK_STREAM_SORTER -- requirements
Module: topk_stream_sorter

Interface
REQ-001 Parameter N, default 64, number of scores per frame; N >= K SHALL hold (elaboration error otherwise).
REQ-002 Parameter WIDTH, default 16, score width in bits.
REQ-003 Parameter IDW, default 6, node-ID width; 2**IDW >= N SHALL hold.
REQ-004 Parameter K, default 10, number of ranked results retained (1..32).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a new frame.
REQ-008 in_valid  input  1  in_score is valid this cycle.
REQ-009 in_ready  output  1  block accepts a score this cycle.
REQ-010 in_score  input  WIDTH  unsigned score; its ID is its arrival index 0..N-1.
REQ-011 topk_vals  output  K*WIDTH  ranked scores; rank 0 (best) in the most significant WIDTH bits.
REQ-012 topk_ids  output  K*IDW  IDs matching topk_vals, same slot ordering.
REQ-013 busy  output  1  high while a frame is being collected.
REQ-014 done  output  1  one-cycle pulse: topk_vals/topk_ids updated with a completed frame.

Function
REQ-015 FSM states IDLE, COLLECT, DONE; IDLE->COLLECT on start; COLLECT->DONE on the Nth accepted score; DONE->IDLE after one cycle, or DONE->COLLECT if start is high in that cycle.
REQ-016 A score is accepted on a cycle with in_valid && in_ready; in_ready SHALL equal (state == COLLECT).
REQ-017 On entry to COLLECT, the internal K-entry table SHALL be cleared (all slots invalid) and the ID counter set to 0.
REQ-018 Each accepted score SHALL be compared in parallel against all valid table slots and inserted in the same cycle, shifting lower-ranked entries down one slot and discarding the entry pushed past slot K-1.
REQ-019 A score lower than all K valid entries SHALL be discarded; invalid slots always rank below any score.
REQ-020 Ties: an equal score SHALL rank below the existing entry (earlier ID wins).
REQ-021 The ID counter SHALL increment by 1 per accepted score, width IDW, and SHALL not wrap within a frame.
REQ-022 done SHALL be high exactly in the cycle after the Nth accept (DONE state); topk_vals/topk_ids SHALL update in that same cycle and hold until the next done.
REQ-023 start while in COLLECT SHALL abort the frame and restart it (REQ-017); a score presented in the same cycle is not accepted.
REQ-024 start in IDLE with in_valid high: start takes effect, score not accepted (in_ready low).
REQ-025 busy SHALL equal (state == COLLECT).

Reset
REQ-026 reset SHALL force state IDLE, in_ready 0, busy 0, done 0, topk_vals 0, topk_ids 0, table invalid, ID counter 0, regardless of clock.
REQ-027 reset mid-frame SHALL discard the partial frame; no done pulse SHALL follow.

Configuration
REQ-028 Macro TOPK_MIN_MODE_EN: when defined, the block SHALL retain the K smallest scores (rank 0 = smallest, ties still favour earlier ID, invalid slots rank below any score); when undefined, the K largest as above.

Verification
REQ-029 Defaults, start, scores id*3 for id 0..63 back-to-back -> done one cycle after 64th accept; topk_vals 189,186,...,162; topk_ids 63..54 (rank 0 first).
REQ-030 All 64 scores 0x0100 -> topk_vals all 0x0100, topk_ids 0,1,...,9.
REQ-031 Same stimulus as REQ-029 with in_valid toggling 1/0 -> identical result; done one cycle after 64th accept (cycle 127 after start).
REQ-032 20 scores of 0xFFFF, then start, then scores id*3 -> result identical to REQ-029.
REQ-033 reset asserted after 30 accepts -> all outputs 0 immediately, no done; a subsequent full frame yields REQ-029 result.
REQ-034 TOPK_MIN_MODE_EN defined, stimulus of REQ-029 -> topk_vals 0,3,...,27; topk_ids 0..9.
